// File: rtl/alu_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_stage_if
// Description : Handshake and decoded-bundle signals around alu_decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;
  logic [15:0] illegal_cnt;

  // Upstream fetch plus downstream execute, seen from outside the stage
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_ctrl, alu_src_imm, imm,
           rs1, rs2, rd, reg_write, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_ctrl, alu_src_imm, imm,
           rs1, rs2, rd, reg_write, illegal, illegal_cnt
  );
endinterface
`default_nettype wire

// File: rtl/alu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_stage
// Description : RV32 ALU-subset decoder with a 2-entry skid output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode_stage (
  input wire                 clk,
  input wire                 rst,
  alu_decode_stage_if.slave  bus
);

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;
  localparam logic [3:0] c_ALU_MUL = 4'b1000;
  localparam logic [3:0] c_ALU_ILL = 4'b1111;

  localparam logic [6:0] c_OP_R = 7'b0110011;
  localparam logic [6:0] c_OP_I = 7'b0010011;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

  state_t      r_state;
  state_t      w_state_nxt;
  bundle_t     r_main;
  bundle_t     r_skid;
  bundle_t     w_dec;
  logic        w_legal;
  logic        w_accept;
  logic        w_load_main;
  logic        w_load_skid;
  logic        w_skid_to_main;
  logic        w_out_fire;
  logic [15:0] r_illegal_cnt;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;

  assign w_opcode = bus.instr[6:0];
  assign w_f3     = bus.instr[14:12];
  assign w_f7     = bus.instr[31:25];

  always_comb begin
    w_dec             = '0;
    w_legal           = 1'b0;
    w_dec.rs1         = bus.instr[19:15];
    w_dec.rs2         = bus.instr[24:20];
    w_dec.rd          = bus.instr[11:7];
    case (w_opcode)
      c_OP_R: begin
        w_legal = 1'b1;
        case ({w_f7, w_f3})
          10'b0000000_000: w_dec.alu_ctrl = c_ALU_ADD;
          10'b0000000_111: w_dec.alu_ctrl = c_ALU_AND;
          10'b0000000_110: w_dec.alu_ctrl = c_ALU_OR;
          10'b0000000_010: w_dec.alu_ctrl = c_ALU_SLT;
          10'b0100000_000: w_dec.alu_ctrl = c_ALU_SUB;
          10'b0000001_000: w_dec.alu_ctrl = c_ALU_MUL;
          default:         w_legal        = 1'b0;
        endcase
      end
      c_OP_I: begin
        w_legal           = 1'b1;
        w_dec.alu_src_imm = 1'b1;
        w_dec.imm         = {{20{bus.instr[31]}}, bus.instr[31:20]};
        case (w_f3)
          3'b000:  w_dec.alu_ctrl = c_ALU_ADD;
          3'b111:  w_dec.alu_ctrl = c_ALU_AND;
          3'b110:  w_dec.alu_ctrl = c_ALU_OR;
          3'b010:  w_dec.alu_ctrl = c_ALU_SLT;
          default: w_legal        = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    // Illegal words keep their register fields but lose every side effect
    if (!w_legal) begin
      w_dec.alu_ctrl    = c_ALU_ILL;
      w_dec.alu_src_imm = 1'b0;
      w_dec.imm         = '0;
      w_dec.illegal     = 1'b1;
    end
    w_dec.reg_write = w_legal && (w_dec.rd != 5'd0);
  end

  // in_ready depends only on r_state, so out_ready never reaches it combinationally
  assign w_accept   = bus.in_valid && (r_state != S_FULL);
  assign w_out_fire = (r_state != S_EMPTY) && bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && bus.out_ready) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = S_FULL;
        end else if (bus.out_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (bus.out_ready) begin
          w_skid_to_main = 1'b1;
          w_state_nxt    = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_main        <= '0;
      r_skid        <= '0;
      r_illegal_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_main <= w_dec;
      end else if (w_skid_to_main) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
      if (w_out_fire && r_main.illegal && (r_illegal_cnt != 16'hFFFF)) begin
        r_illegal_cnt <= r_illegal_cnt + 16'd1;
      end
    end
  end

  assign bus.in_ready    = (r_state != S_FULL);
  assign bus.out_valid   = (r_state != S_EMPTY);
  assign bus.alu_ctrl    = r_main.alu_ctrl;
  assign bus.alu_src_imm = r_main.alu_src_imm;
  assign bus.imm         = r_main.imm;
  assign bus.rs1         = r_main.rs1;
  assign bus.rs2         = r_main.rs2;
  assign bus.rd          = r_main.rd;
  assign bus.reg_write   = r_main.reg_write;
  assign bus.illegal     = r_main.illegal;
  assign bus.illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream instruction word valid.
REQ-005 in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-006 instr  input  32  RV32 instruction word, sampled when in_valid && in_ready.
REQ-007 out_valid  output  1  decoded bundle valid.
REQ-008 out_ready  input  1  downstream execute stage accepts bundle.
REQ-009 alu_ctrl  output  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 MUL, 0111 SLT, 1111 illegal.
REQ-010 alu_src_imm  output  1  1 = operand b is imm, 0 = operand b is rs2 value.
REQ-011 imm  output  32  sign-extended instr[31:20] for I-type, else 0.
REQ-012 rs1, rs2, rd  output  5 each  instr[19:15], instr[24:20], instr[11:7].
REQ-013 reg_write  output  1  write-back enable; 0 when illegal or rd==0.
REQ-014 illegal  output  1  instruction not in supported set.
REQ-015 illegal_cnt  output  16  count of illegal bundles accepted downstream.

Function
REQ-016 Decode R-type (opcode 0110011): f7=0000000 with f3 000/111/110/010 -> ADD/AND/OR/SLT; f7=0100000,f3=000 -> SUB; f7=0000001,f3=000 -> MUL; alu_src_imm=0.
REQ-017 Decode I-type (opcode 0010011): f3 000/111/110/010 -> ADD/AND/OR/SLT; alu_src_imm=1; imm = {{20{instr[31]}},instr[31:20]}; rs2 output still instr[24:20].
REQ-018 Any other opcode/funct combination: alu_ctrl=1111, illegal=1, reg_write=0, alu_src_imm=0, imm=0.
REQ-019 Decode is combinational on accepted instr; result captured into a main register; latency 1 cycle (accept at edge N -> out_valid at N, bundle visible after edge N).
REQ-020 Buffering is a 2-entry skid: states EMPTY, ONE, FULL.
REQ-021 EMPTY: accept -> ONE.
REQ-022 ONE: accept && out_ready -> ONE (main reloaded); accept && !out_ready -> FULL (new bundle to skid); !accept && out_ready -> EMPTY; else hold.
REQ-023 FULL: out_ready -> ONE (skid moves to main); else hold; in_ready=0 in FULL.
REQ-024 in_ready = 1 in EMPTY and ONE, 0 in FULL; derived from registered state only.
REQ-025 out_valid = 1 in ONE and FULL; output bundle always from main register; bundle SHALL not change while out_valid && !out_ready.
REQ-026 Ordering strictly preserved; no bundle dropped or duplicated.
REQ-027 illegal_cnt increments by 1 on each cycle out_valid && out_ready && illegal; saturates at 0xFFFF.
REQ-028 in_valid while in_ready=0 SHALL be ignored; instr need not be held stable by this block's contract beyond the accept cycle.

Reset
REQ-029 On rst, state=EMPTY, out_valid=0, in_ready=1 (first cycle after rst deasserts), illegal_cnt=0.
REQ-030 On rst, main and skid registers clear: alu_ctrl=0000, alu_src_imm=0, imm=0, rs1=rs2=rd=0, reg_write=0, illegal=0.
REQ-031 rst asserted mid-operation (ONE or FULL) SHALL discard all buffered bundles; rst has priority over any handshake that cycle.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, rs1=1, rs2=2, rd=3, reg_write=1, alu_src_imm=0.
REQ-033 ADDI x5,x0,-1 (0xFFF00293) -> alu_ctrl=0010, alu_src_imm=1, imm=0xFFFFFFFF, reg_write=1; SUB 0x40208133 -> alu_ctrl=0110; MUL 0x02208133 -> alu_ctrl=1000.
REQ-034 Back-to-back stream of 8 valid instrs with out_ready=1 -> 8 bundles, one per cycle, in order, in_ready constantly 1.
REQ-035 out_ready=0 while sending 3 instrs -> state FULL after 2 accepts, in_ready=0, third held off; release out_ready -> bundles 1,2,3 in order, no loss.
REQ-036 Load 0x00002083 accepted, then ADD with rd=0 -> first illegal=1, alu_ctrl=1111, illegal_cnt=1 after handshake; second reg_write=0.
REQ-037 Reset asserted in FULL state -> next cycle out_valid=0, in_ready=1, illegal_cnt=0, no stale bundle emitted.
